wave_sample_sequencer: RTL and testbench

Playback sequencer for the 4-bit wave channel. It steps through the two 16-byte wave RAM banks, one sample per frequency-timer tick, and handles the 32/64-sample bank modes, trigger restart and the channel enable. It applies the NR32 output level and produces a registered 4-bit sample for the channel mixer input. It consumes frequency_timer_clock from the existing frequency_timer instance.

---
 rtl/gba_sound_pkg.sv | 39 +++
 rtl/wave_volume_scaler.sv | 33 +++
 rtl/wave_sample_sequencer.sv | 131 +++++++++++++
 tb/tb_wave_sample_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_sound_pkg.sv
// Shared types and register bit positions for the GBA sound channels.
package gba_sound_pkg;

    // Wave sequencer playback state.
    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } wave_seq_state_t;

    // NR32[6:5] volume codes.
    localparam logic [1:0] VOL_MUTE = 2'b00;
    localparam logic [1:0] VOL_100  = 2'b01;
    localparam logic [1:0] VOL_50   = 2'b10;
    localparam logic [1:0] VOL_25   = 2'b11;

    // NR30 bit positions.
    localparam int ENABLE_BIT = 7;
    localparam int BANK_BIT   = 6;
    localparam int DIM_BIT    = 5;

    // NR32 bit positions.
    localparam int FORCE75_BIT = 7;

    // Geometry of one wave RAM bank.
    localparam int BANK_BYTES = 16;
    localparam int BANK_BITS  = BANK_BYTES * 8;

    // Pick the nibble played at a given position: byte pos[4:1],
    // high nibble first for even positions, low nibble for odd ones.
    function automatic logic [3:0] select_nibble(
        input logic [BANK_BITS-1:0] pattern,
        input logic [4:0]           pos
    );
        logic [7:0] byte_value;
        byte_value = pattern[{pos[4:1], 3'b000} +: 8];
        return pos[0] ? byte_value[3:0] : byte_value[7:4];
    endfunction

endpackage

// File: rtl/wave_volume_scaler.sv
// Combinational NR32 output-level scaler for a raw 4-bit wave nibble.
// volume_control is NR32[7:5]: [2] forces 75 %, [1:0] is the volume code.
module wave_volume_scaler
    import gba_sound_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic [2:0] volume_control,
    output logic [3:0] scaled
);

    logic [5:0] triple;

    // 3*n computed as n + 2n so the 75 % level is (3n)>>2 without a multiplier.
    assign triple = {2'b00, nibble} + {1'b0, nibble, 1'b0};

    // Select the output level; the force-75 % bit overrides the volume code.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        scaled = 4'd0;
        if (volume_control[2]) begin
            scaled = triple[5:2];
        end else begin
            case (volume_control[1:0])
                VOL_MUTE: scaled = 4'd0;
                VOL_100:  scaled = nibble;
                VOL_50:   scaled = {1'b0, nibble[3:1]};
                VOL_25:   scaled = {2'b00, nibble[3:2]};
                default:  scaled = 4'd0;
            endcase
        end
    end

endmodule

// File: rtl/wave_sample_sequencer.sv
// Wave channel playback sequencer: steps through the wave RAM banks one
// nibble per frequency-timer tick, handles 32/64-sample modes, trigger
// restart and channel enable, and registers the volume-scaled sample.
module wave_sample_sequencer
    import gba_sound_pkg::*;
#(
    parameter int SAMPLES_PER_BANK = 32
) (
    input  logic         frequency_timer_clock,
    input  logic         reset,
    input  logic [7:0]   NR30,
    input  logic [7:0]   NR32,
    input  logic         trigger,
    input  logic [127:0] bank0_pattern,
    input  logic [127:0] bank1_pattern,
    output logic [3:0]   sample,
    output logic [4:0]   position,
    output logic         active_bank,
    output logic         wrap,
    output logic         playing
);

    localparam logic [4:0] LAST_POSITION = 5'(SAMPLES_PER_BANK - 1);

    wave_seq_state_t state;
    wave_seq_state_t state_next;

    logic       trigger_q;
    logic       trig_edge;
    logic       enable;
    logic       bank_select;
    logic       dimension;

    logic [3:0] sample_next;
    logic [4:0] position_next;
    logic       active_bank_next;
    logic       wrap_next;

    logic [3:0] raw_nibble;
    logic [3:0] scaled_nibble;

    // Register bits this block does not look at, gathered in one place.
    logic       unused_register_bits;
    assign unused_register_bits = ^{NR30[4:0], NR32[4:0]};

    assign enable      = NR30[ENABLE_BIT];
    assign bank_select = NR30[BANK_BIT];
    assign dimension   = NR30[DIM_BIT];
    assign trig_edge   = trigger & ~trigger_q;
    assign playing     = (state == PLAY);

    // Raw nibble at the current position of the bank being played; pattern
    // writes are seen live because nothing is cached here.
    assign raw_nibble = select_nibble(active_bank ? bank1_pattern : bank0_pattern,
                                      position);

    wave_volume_scaler u_volume_scaler (
        .nibble         (raw_nibble),
        .volume_control (NR32[FORCE75_BIT:5]),
        .scaled         (scaled_nibble)
    );

    // State and output registers; everything clears asynchronously on reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge frequency_timer_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            trigger_q   <= 1'b0;
            sample      <= 4'd0;
            position    <= 5'd0;
            active_bank <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state       <= state_next;
            trigger_q   <= trigger;
            sample      <= sample_next;
            position    <= position_next;
            active_bank <= active_bank_next;
            wrap        <= wrap_next;
        end
    end

    // Next-state and next-output logic: disable beats trigger, trigger beats a normal step.
    always_comb begin
        state_next       = state;
        sample_next      = sample;
        position_next    = position;
        active_bank_next = active_bank;
        wrap_next        = 1'b0;

        case (state)
            IDLE: begin
                sample_next   = 4'd0;
                position_next = 5'd0;
                if (enable && trig_edge) begin
                    state_next       = PLAY;
                    active_bank_next = bank_select;
                end
            end

            PLAY: begin
                if (!enable) begin
                    state_next    = IDLE;
                    sample_next   = 4'd0;
                    position_next = 5'd0;
                end else if (trig_edge) begin
                    // Restart wins over a wrap on the same tick; wrap stays low.
                    sample_next      = 4'd0;
                    position_next    = 5'd0;
                    active_bank_next = bank_select;
                end else begin
                    sample_next = scaled_nibble;
                    if (position == LAST_POSITION) begin
                        position_next    = 5'd0;
                        wrap_next        = 1'b1;
                        active_bank_next = dimension ? ~active_bank : bank_select;
                    end else begin
                        position_next = position + 5'd1;
                    end
                end
            end

            default: begin
                state_next    = IDLE;
                sample_next   = 4'd0;
                position_next = 5'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_wave_sample_sequencer.sv
// Self-checking bench for wave_sample_sequencer: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a behavioural model of the playback rules.
module tb_wave_sample_sequencer;

    logic         clk;
    logic         reset;
    logic [7:0]   NR30;
    logic [7:0]   NR32;
    logic         trigger;
    logic [127:0] bank0_pattern;
    logic [127:0] bank1_pattern;
    logic [3:0]   sample;
    logic [4:0]   position;
    logic         active_bank;
    logic         wrap;
    logic         playing;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    wave_sample_sequencer dut (
        .frequency_timer_clock (clk),
        .reset                 (reset),
        .NR30                  (NR30),
        .NR32                  (NR32),
        .trigger               (trigger),
        .bank0_pattern         (bank0_pattern),
        .bank1_pattern         (bank1_pattern),
        .sample                (sample),
        .position              (position),
        .active_bank           (active_bank),
        .wrap                  (wrap),
        .playing               (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit       play;
        bit [4:0] pos;
        bit       bank;
        bit [3:0] smp;
        bit       wrap;
        bit       trig_prev;
    } model_t;

    model_t m;

    function automatic int nibble_at(input logic [127:0] pat, input int p);
        logic [7:0] by;
        by = pat[(p / 2) * 8 +: 8];
        return (p % 2 == 0) ? int'(by) / 16 : int'(by) % 16;
    endfunction

    function automatic int scale(input int n, input logic [7:0] nr32);
        if (nr32[7]) return (n * 3) / 4;
        case (nr32[6:5])
            2'd0:    return 0;
            2'd1:    return n;
            2'd2:    return n / 2;
            default: return n / 4;
        endcase
    endfunction

    function automatic model_t model_step(input model_t cur, input logic [7:0] nr30,
                                          input logic [7:0] nr32, input logic trig,
                                          input logic [127:0] b0, input logic [127:0] b1);
        model_t nx;
        bit     edge_seen;
        int     p;
        nx = cur;
        edge_seen = trig && !cur.trig_prev;
        nx.trig_prev = trig;
        nx.wrap = 1'b0;
        if (!cur.play) begin
            nx.smp = 0;
            nx.pos = 0;
            if (nr30[7] && edge_seen) begin
                nx.play = 1'b1;
                nx.bank = nr30[6];
            end
        end else if (!nr30[7]) begin
            nx.play = 1'b0;
            nx.smp  = 0;
            nx.pos  = 0;
        end else if (edge_seen) begin
            nx.smp  = 0;
            nx.pos  = 0;
            nx.bank = nr30[6];
        end else begin
            p = int'(cur.pos);
            nx.smp = 4'(scale(nibble_at(cur.bank ? b1 : b0, p), nr32));
            if (p == 31) begin
                nx.wrap = 1'b1;
                nx.bank = nr30[5] ? !cur.bank : nr30[6];
            end
            nx.pos = 5'((p + 1) % 32);
        end
        return nx;
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_step(m, NR30, NR32, trigger, bank0_pattern, bank1_pattern);
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("model_sample",   int'(sample),      int'(m.smp));
            check("model_position", int'(position),    int'(m.pos));
            check("model_bank",     int'(active_bank), int'(m.bank));
            check("model_wrap",     int'(wrap),        int'(m.wrap));
            check("model_playing",  int'(playing),     int'(m.play));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (int'(position) != target && n < 100) begin
            tick();
            n++;
        end
        if (int'(position) != target) check("wait_pos_timeout", int'(position), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp1 [5];
        int vol_exp [5];
        logic [7:0] vol_nr32 [5];

        reset = 1'b0;
        NR30 = 8'h00;
        NR32 = 8'h00;
        trigger = 1'b0;
        bank0_pattern = '0;
        bank1_pattern = '0;
        #2 reset = 1'b1;
        #1;
        check("reset_sample",   int'(sample),      0);
        check("reset_position", int'(position),    0);
        check("reset_bank",     int'(active_bank), 0);
        check("reset_wrap",     int'(wrap),        0);
        check("reset_playing",  int'(playing),     0);
        check_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Test 1: 32-sample full-volume playback.
        bank0_pattern[7:0]  = 8'h1F;
        bank0_pattern[15:8] = 8'hA2;
        NR30 = 8'h80;
        NR32 = 8'h20;
        trigger = 1'b1;
        exp1 = '{0, 1, 15, 10, 2};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_sample", int'(sample), exp1[i]);
        end
        check("t1_playing", int'(playing), 1);
        check("t1_bank", int'(active_bank), 0);

        // Test 3: volume codes on an all-F pattern; NR32 applies on the next tick.
        bank0_pattern = {128{1'b1}};
        vol_nr32 = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80};
        vol_exp  = '{0, 15, 7, 3, 11};
        for (int i = 0; i < 5; i++) begin
            NR32 = vol_nr32[i];
            tick();
            check("t3_volume", int'(sample), vol_exp[i]);
        end

        // Test 2: 64-sample mode wrap into bank 1.
        NR32 = 8'h20;
        NR30 = 8'hA0;
        trigger = 1'b0;
        bank1_pattern = '0;
        bank1_pattern[7:0] = 8'h70;
        tick();
        trigger = 1'b1;
        tick();
        check("t2_restart_pos", int'(position), 0);
        for (int i = 0; i < 31; i++) begin
            tick();
            check("t2_no_wrap", int'(wrap), 0);
        end
        tick();
        check("t2_wrap", int'(wrap), 1);
        check("t2_bank_toggle", int'(active_bank), 1);
        check("t2_wrap_pos", int'(position), 0);
        tick();
        check("t2_wrap_once", int'(wrap), 0);
        check("t2_sample_7", int'(sample), 7);
        tick();
        check("t2_sample_0", int'(sample), 0);

        // Test 4: disable at position 10, then a trigger while disabled.
        wait_pos(10);
        NR30 = 8'h20;
        tick();
        check("t4_playing", int'(playing), 0);
        check("t4_sample", int'(sample), 0);
        check("t4_position", int'(position), 0);
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        check("t4_ignored_trigger", int'(playing), 0);

        // Test 5: retrigger on the wrap tick in 64-sample mode, bank 1 selected.
        NR30 = 8'hE0;
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        check("t5_started", int'(playing), 1);
        check("t5_start_bank", int'(active_bank), 1);
        trigger = 1'b0;
        wait_pos(31);
        trigger = 1'b1;
        tick();
        check("t5_pos", int'(position), 0);
        check("t5_bank_no_toggle", int'(active_bank), 1);
        check("t5_wrap", int'(wrap), 0);
        tick();
        check("t5_held_trigger", int'(position), 1);

        // Test 6: asynchronous reset mid-play.
        trigger = 1'b0;
        NR30 = 8'h80;
        wait_pos(20);
        #2 reset = 1'b1;
        #1;
        check("t6_sample", int'(sample), 0);
        check("t6_position", int'(position), 0);
        check("t6_bank", int'(active_bank), 0);
        check("t6_wrap", int'(wrap), 0);
        check("t6_playing", int'(playing), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t6_stays_idle", int'(playing), 0);
        trigger = 1'b1;
        tick();
        check("t6_resumed", int'(playing), 1);

        // Randomized phase, checked by the compare process.
        for (int i = 0; i < 800; i++) begin
            NR30 = {($urandom_range(0, 99) < 95) ? 1'b1 : 1'b0, 2'($urandom), 5'($urandom)};
            if ($urandom_range(0, 9) == 0) NR32 = 8'($urandom);
            if ($urandom_range(0, 99) < 4) trigger = ~trigger;
            if ($urandom_range(0, 99) < 5) begin
                if ($urandom_range(0, 1) == 0) bank0_pattern[$urandom_range(0, 15) * 8 +: 8] = 8'($urandom);
                else                           bank1_pattern[$urandom_range(0, 15) * 8 +: 8] = 8'($urandom);
            end
            tick();
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
